fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the pipelined CPU. It replaces the purely combinational EX-stage forwarding mux selection with a self-contained block. The block tracks the destination tags of every in-flight instruction in an internal tag pipeline, registers the ID-stage source operands into EX, generates per-operand forward selects, detects load-use hazards and issues stall/bubble, and counts stall cycles. It sits beside the ID/EX pipeline register and drives the EX operand muxes and the PC/IF-ID write enables.

---
 rtl/fwd_hazard_unit_pkg.sv | 12 +
 rtl/fwd_hazard_unit_if.sv | 36 +++
 rtl/fwd_hazard_unit_select.sv | 26 ++
 rtl/fwd_hazard_unit.sv | 97 +++++++++
 tb/tb_fwd_hazard_unit.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit: tag-pipeline entry and select encoding.
package fwd_pkg;
    localparam int REG_AW_MAX = 8;  // widest register address the tag entry can carry
    localparam int FWD_RF     = 0;  // select value meaning "take the register file"

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  regWrite;
        logic                  memRead;
    } tagEntry_t;
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage operand/control bundle into the forwarding unit and its EX-mux/stall outputs.
interface fwd_hazard_unit_if #(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 2,
    parameter int CNT_W     = 16
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              flush;
    logic              hold;
    logic [SEL_W-1:0]  fwd_a;
    logic [SEL_W-1:0]  fwd_b;
    logic              stall;
    logic              bubble;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
               id_reg_write, id_mem_read, flush, hold,
        input  fwd_a, fwd_b, stall, bubble, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
               id_reg_write, id_mem_read, flush, hold,
        output fwd_a, fwd_b, stall, bubble, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit_select.sv
// Priority match of one EX source against the downstream tag entries; nearest producer wins.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int SEL_W     = 2
) (
    input  tagEntry_t [FWD_DEPTH:1]  tags,
    input  logic [REG_AW_MAX-1:0]    src,
    input  logic                     used,
    output logic [SEL_W-1:0]         sel
);
    logic unusedTagBits;
    assign unusedTagBits = ^tags;

    // Scan far-to-near so the last hit written is the closest stage.
    always_comb begin
        sel = SEL_W'(FWD_RF);
        if (used && src != '0) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (tags[k].valid && tags[k].regWrite && tags[k].rd == src)
                    sel = SEL_W'(k);
            end
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tag pipeline behind EX, operand selects, stall/bubble, stall counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16
) (
    input logic              clk,
    input logic              rst_n,
    fwd_hazard_unit_if.slave bus
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    tagEntry_t [FWD_DEPTH:0]  tagPipe;
    tagEntry_t                idEntry;
    logic [REG_AW_MAX-1:0]    idRs, idRt, idRd;
    logic [REG_AW_MAX-1:0]    exRs, exRt;
    logic                     exRsUsed, exRtUsed;
    logic [CNT_W-1:0]         stallCnt;
    logic                     hazard, stallInt, accept;

    always_comb begin
        idRs = '0;
        idRt = '0;
        idRd = '0;
        idRs[REG_AW-1:0] = bus.id_rs;
        idRt[REG_AW-1:0] = bus.id_rt;
        idRd[REG_AW-1:0] = bus.id_rd;
    end

    // Loads in entries 0..LOAD_STAGE-2 have no forwardable data yet.
    always_comb begin
        hazard = 1'b0;
        for (int s = 0; s < LOAD_STAGE - 1; s++) begin
            if (tagPipe[s].valid && tagPipe[s].memRead && tagPipe[s].rd != '0 &&
                ((bus.id_rs_used && tagPipe[s].rd == idRs) ||
                 (bus.id_rt_used && tagPipe[s].rd == idRt)))
                hazard = 1'b1;
        end
        hazard = hazard & bus.id_valid;
    end

    // Gating with rst_n makes stall fall the instant reset is asserted.
    assign stallInt = hazard & ~bus.flush & rst_n;
    assign accept   = bus.id_valid & ~stallInt & ~bus.flush;

    always_comb begin
        idEntry = '0;
        if (accept) begin
            idEntry.valid    = 1'b1;
            idEntry.rd       = idRd;
            idEntry.regWrite = bus.id_reg_write;
            idEntry.memRead  = bus.id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tagPipe  <= '0;
            exRs     <= '0;
            exRt     <= '0;
            exRsUsed <= 1'b0;
            exRtUsed <= 1'b0;
            stallCnt <= '0;
        end else if (!bus.hold) begin
            for (int k = 1; k <= FWD_DEPTH; k++)
                tagPipe[k] <= tagPipe[k-1];
            tagPipe[0] <= idEntry;
            exRs       <= accept ? idRs : '0;
            exRt       <= accept ? idRt : '0;
            exRsUsed   <= accept & bus.id_rs_used;
            exRtUsed   <= accept & bus.id_rt_used;
            if (stallInt && stallCnt != {CNT_W{1'b1}})
                stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    fwd_select #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) selA (
        .tags (tagPipe[FWD_DEPTH:1]),
        .src  (exRs),
        .used (exRsUsed),
        .sel  (bus.fwd_a)
    );

    fwd_select #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) selB (
        .tags (tagPipe[FWD_DEPTH:1]),
        .src  (exRt),
        .used (exRtUsed),
        .sel  (bus.fwd_b)
    );

    assign bus.stall     = stallInt;
    assign bus.bubble    = stallInt;
    assign bus.stall_cnt = stallCnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: default instance plus a LOAD_STAGE=3 / narrow-counter instance, with a scoreboard.
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_AW(5), .FWD_DEPTH(2), .CNT_W(16)) ifc0 ();
    fwd_hazard_unit_if #(.REG_AW(5), .FWD_DEPTH(3), .CNT_W(3))  ifc1 ();

    fwd_hazard_unit #(.REG_AW(5), .FWD_DEPTH(2), .LOAD_STAGE(2), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(ifc0));
    fwd_hazard_unit #(.REG_AW(5), .FWD_DEPTH(3), .LOAD_STAGE(3), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(ifc1));

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic       rsU;
        logic [4:0] rt;
        logic       rtU;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct packed {
        int          d;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    localparam int FD   [2] = '{2, 3};
    localparam int LS   [2] = '{2, 3};
    localparam int CMAX [2] = '{65535, 7};
    localparam instr_t IDLE = '0;

    int nCmp = 0;
    int nErr = 0;
    exp_t sb[$];
    int stCyc[2];

    // Reference state: tags per instance, EX sources, counter.
    logic       mV  [2][4];
    logic [4:0] mRd [2][4];
    logic       mRw [2][4];
    logic       mMr [2][4];
    logic [4:0] mExRs[2], mExRt[2];
    logic       mExRsU[2], mExRtU[2];
    int         mCnt[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nCmp++;
        if (got !== want) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] rd, input logic [4:0] rs, input logic rsU,
                                  input logic [4:0] rt, input logic rtU, input logic rw, input logic mr);
        instr_t i;
        i.v = 1'b1; i.rs = rs; i.rsU = rsU; i.rt = rt; i.rtU = rtU;
        i.rd = rd; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return mk(rd, rs, 1'b1, rt, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic instr_t ld(input logic [4:0] rd, input logic [4:0] rs);
        return mk(rd, rs, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
    endfunction

    function automatic logic [1:0] srcSel(input int d, input logic [4:0] r, input logic u);
        if (!u || r == 5'd0) return 2'd0;
        for (int k = 1; k <= FD[d]; k++)
            if (mV[d][k] && mRw[d][k] && mRd[d][k] == r) return 2'(k);
        return 2'd0;
    endfunction

    function automatic exp_t modelOut(input int d, input instr_t in, input logic fl);
        exp_t e;
        logic haz;
        haz = 1'b0;
        for (int s = 0; s <= LS[d] - 2; s++)
            if (in.v && mV[d][s] && mMr[d][s] && mRd[d][s] != 5'd0 &&
                ((in.rsU && in.rs == mRd[d][s]) || (in.rtU && in.rt == mRd[d][s])))
                haz = 1'b1;
        e.d     = d;
        e.fa    = srcSel(d, mExRs[d], mExRsU[d]);
        e.fb    = srcSel(d, mExRt[d], mExRtU[d]);
        e.stall = haz && !fl && rst_n;
        e.cnt   = 16'(mCnt[d]);
        return e;
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                mV[d][k] = 1'b0; mRd[d][k] = '0; mRw[d][k] = 1'b0; mMr[d][k] = 1'b0;
            end
            mExRs[d] = '0; mExRt[d] = '0; mExRsU[d] = 1'b0; mExRtU[d] = 1'b0;
            mCnt[d] = 0;
        end
    endtask

    task automatic modelEdge(input int d, input instr_t in, input logic fl, input logic hd);
        exp_t e;
        logic acc;
        e = modelOut(d, in, fl);
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                mV[d][k] = 1'b0; mRd[d][k] = '0; mRw[d][k] = 1'b0; mMr[d][k] = 1'b0;
            end
            mExRs[d] = '0; mExRt[d] = '0; mExRsU[d] = 1'b0; mExRtU[d] = 1'b0;
            mCnt[d] = 0;
        end else if (!hd) begin
            for (int k = FD[d]; k >= 1; k--) begin
                mV[d][k] = mV[d][k-1]; mRd[d][k] = mRd[d][k-1];
                mRw[d][k] = mRw[d][k-1]; mMr[d][k] = mMr[d][k-1];
            end
            acc = in.v && !e.stall && !fl;
            mV[d][0]  = acc;
            mRd[d][0] = acc ? in.rd : 5'd0;
            mRw[d][0] = acc && in.rw;
            mMr[d][0] = acc && in.mr;
            mExRs[d]  = acc ? in.rs : 5'd0;
            mExRt[d]  = acc ? in.rt : 5'd0;
            mExRsU[d] = acc && in.rsU;
            mExRtU[d] = acc && in.rtU;
            if (e.stall && mCnt[d] < CMAX[d]) mCnt[d]++;
        end
    endtask

    task automatic drv(input instr_t i0, input instr_t i1, input logic fl, input logic hd);
        ifc0.id_valid = i0.v;  ifc0.id_rs = i0.rs; ifc0.id_rs_used = i0.rsU;
        ifc0.id_rt = i0.rt;    ifc0.id_rt_used = i0.rtU; ifc0.id_rd = i0.rd;
        ifc0.id_reg_write = i0.rw; ifc0.id_mem_read = i0.mr;
        ifc0.flush = fl; ifc0.hold = hd;
        ifc1.id_valid = i1.v;  ifc1.id_rs = i1.rs; ifc1.id_rs_used = i1.rsU;
        ifc1.id_rt = i1.rt;    ifc1.id_rt_used = i1.rtU; ifc1.id_rd = i1.rd;
        ifc1.id_reg_write = i1.rw; ifc1.id_mem_read = i1.mr;
        ifc1.flush = fl; ifc1.hold = hd;
    endtask

    // One cycle: drive, queue expectations, sample stall at negedge, advance the model at the edge.
    task automatic step(input instr_t i0, input instr_t i1, input logic fl, input logic hd,
                        output logic s0, output logic s1);
        drv(i0, i1, fl, hd);
        sb.push_back(modelOut(0, i0, fl));
        sb.push_back(modelOut(1, i1, fl));
        @(negedge clk);
        s0 = ifc0.stall;
        s1 = ifc1.stall;
        @(posedge clk);
        modelEdge(0, i0, fl, hd);
        modelEdge(1, i1, fl, hd);
        #1;
    endtask

    // Present an instruction until accepted, counting the stall cycles seen on each instance.
    task automatic issue(input instr_t a0, input instr_t a1);
        instr_t c0, c1;
        logic s0, s1;
        int n;
        c0 = a0; c1 = a1; n = 0;
        stCyc[0] = 0; stCyc[1] = 0;
        do begin
            step(c0, c1, 1'b0, 1'b0, s0, s1);
            if (s0) stCyc[0]++; else c0 = IDLE;
            if (s1) stCyc[1]++; else c1 = IDLE;
            n++;
        end while ((s0 || s1) && n < 12);
        if (s0 || s1) chk("stallReleaseBound", 32'(s0 | s1), 32'd0);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.d == 0) begin
                chk("fwdA0",   32'(ifc0.fwd_a),     32'(e.fa));
                chk("fwdB0",   32'(ifc0.fwd_b),     32'(e.fb));
                chk("stall0",  32'(ifc0.stall),     32'(e.stall));
                chk("bubble0", 32'(ifc0.bubble),    32'(e.stall));
                chk("cnt0",    32'(ifc0.stall_cnt), 32'(e.cnt));
            end else begin
                chk("fwdA1",   32'(ifc1.fwd_a),     32'(e.fa));
                chk("fwdB1",   32'(ifc1.fwd_b),     32'(e.fb));
                chk("stall1",  32'(ifc1.stall),     32'(e.stall));
                chk("bubble1", 32'(ifc1.bubble),    32'(e.stall));
                chk("cnt1",    32'(ifc1.stall_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic s0, s1;
        instr_t c0, c1;
        logic fl, hd;

        rst_n = 1'b0;
        modelReset();
        drv(IDLE, IDLE, 1'b0, 1'b0);
        @(posedge clk); #1;
        step(IDLE, IDLE, 1'b0, 1'b0, s0, s1);
        step(alu(3, 3, 3), IDLE, 1'b0, 1'b0, s0, s1);
        chk("rstFwdA", 32'(ifc0.fwd_a), 32'd0);
        chk("rstStall", 32'(ifc0.stall), 32'd0);
        chk("rstCnt", 32'(ifc0.stall_cnt), 32'd0);
        rst_n = 1'b1;

        // Back-to-back ALU dependency
        issue(alu(3, 1, 2), IDLE);
        issue(alu(4, 3, 3), IDLE);
        chk("b2bStall", 32'(stCyc[0]), 32'd0);
        chk("b2bFwdA", 32'(ifc0.fwd_a), 32'd1);
        chk("b2bFwdB", 32'(ifc0.fwd_b), 32'd1);

        // Nearest producer wins; lone two-ahead producer selects stage 2
        issue(alu(5, 1, 1), IDLE);
        issue(alu(5, 2, 2), IDLE);
        issue(alu(6, 5, 0), IDLE);
        chk("nearestFwdA", 32'(ifc0.fwd_a), 32'd1);
        chk("r0SrcFwdB", 32'(ifc0.fwd_b), 32'd0);
        issue(alu(5, 1, 1), IDLE);
        issue(alu(9, 1, 2), IDLE);
        issue(alu(6, 5, 0), IDLE);
        chk("farFwdA", 32'(ifc0.fwd_a), 32'd2);

        // Load-use, LOAD_STAGE=2 then LOAD_STAGE=3
        issue(ld(7, 1), IDLE);
        issue(alu(8, 7, 0), IDLE);
        chk("luStallCyc0", 32'(stCyc[0]), 32'd1);
        chk("luFwdA0", 32'(ifc0.fwd_a), 32'd2);
        chk("luCnt0", 32'(ifc0.stall_cnt), 32'd1);
        issue(IDLE, ld(7, 1));
        issue(IDLE, alu(8, 7, 0));
        chk("luStallCyc1", 32'(stCyc[1]), 32'd2);
        chk("luFwdA1", 32'(ifc1.fwd_a), 32'd3);
        chk("luCnt1", 32'(ifc1.stall_cnt), 32'd2);

        // r0 destinations and unused sources
        issue(alu(0, 1, 1), IDLE);
        issue(alu(3, 0, 0), IDLE);
        chk("r0DstFwdA", 32'(ifc0.fwd_a), 32'd0);
        issue(ld(0, 1), IDLE);
        issue(alu(3, 0, 1), IDLE);
        chk("r0LoadStall", 32'(stCyc[0]), 32'd0);
        issue(ld(7, 1), IDLE);
        issue(mk(5'd8, 5'd7, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0), IDLE);
        chk("unusedStall", 32'(stCyc[0]), 32'd0);
        chk("unusedFwdA", 32'(ifc0.fwd_a), 32'd0);

        // Flush coincident with load-use kills the consumer
        issue(ld(7, 1), IDLE);
        step(alu(8, 7, 0), IDLE, 1'b1, 1'b0, s0, s1);
        chk("flushStall", 32'(s0), 32'd0);
        issue(alu(9, 8, 0), IDLE);
        chk("flushKillFwdA", 32'(ifc0.fwd_a), 32'd0);

        // Hold during a load-use stall
        issue(ld(7, 1), IDLE);
        repeat (3) begin
            step(alu(8, 7, 0), IDLE, 1'b0, 1'b1, s0, s1);
            chk("holdStall", 32'(s0), 32'd1);
        end
        chk("holdCntFrozen", 32'(ifc0.stall_cnt), 32'd1);
        step(alu(8, 7, 0), IDLE, 1'b0, 1'b0, s0, s1);
        chk("holdReleaseStall", 32'(s0), 32'd1);
        issue(alu(8, 7, 0), IDLE);
        chk("holdAccept", 32'(stCyc[0]), 32'd0);
        chk("holdCnt", 32'(ifc0.stall_cnt), 32'd2);
        chk("holdFwdA", 32'(ifc0.fwd_a), 32'd2);

        // Saturation of the 3-bit counter
        repeat (4) begin
            issue(IDLE, ld(7, 1));
            issue(IDLE, alu(8, 7, 0));
        end
        chk("satCnt1", 32'(ifc1.stall_cnt), 32'd7);

        // Random traffic on both instances, stalled instructions re-presented
        c0 = IDLE; c1 = IDLE;
        for (int i = 0; i < 300; i++) begin
            fl = ($urandom_range(0, 9) == 0);
            hd = ($urandom_range(0, 7) == 0);
            step(c0, c1, fl, hd, s0, s1);
            if (!(s0 || hd) || fl)
                c0 = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                        5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
            if (!(s1 || hd) || fl)
                c1 = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                        5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
            c0.v = ($urandom_range(0, 7) != 0);
            c1.v = ($urandom_range(0, 7) != 0);
        end
        issue(IDLE, IDLE);
        issue(IDLE, IDLE);

        // Asynchronous reset in the middle of a stall
        issue(ld(7, 1), IDLE);
        drv(alu(8, 7, 0), IDLE, 1'b0, 1'b0);
        #2;
        chk("preRstStall", 32'(ifc0.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("asyncRstStall", 32'(ifc0.stall), 32'd0);
        chk("asyncRstBubble", 32'(ifc0.bubble), 32'd0);
        modelReset();
        step(alu(8, 7, 0), IDLE, 1'b0, 1'b0, s0, s1);
        step(IDLE, IDLE, 1'b0, 1'b0, s0, s1);
        rst_n = 1'b1;
        step(IDLE, IDLE, 1'b0, 1'b0, s0, s1);
        chk("postRstFwdA", 32'(ifc0.fwd_a), 32'd0);
        chk("postRstFwdB", 32'(ifc0.fwd_b), 32'd0);
        chk("postRstCnt0", 32'(ifc0.stall_cnt), 32'd0);
        chk("postRstCnt1", 32'(ifc1.stall_cnt), 32'd0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
